// File: rtl/i2s_pkg.sv
// Shared register map, STATUS/CTRL bit positions and IRQ indices for the I2S APB register bank.
package i2s_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_TXDATA   = 8'h04;
  localparam logic [7:0] OFF_RXDATA   = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h14;

  localparam int ST_TX_FULL    = 16;
  localparam int ST_TX_EMPTY   = 17;
  localparam int ST_RX_NEMPTY  = 18;
  localparam int ST_TX_OVR     = 19;
  localparam int ST_RX_UDR     = 20;
  localparam int ST_TX_CNT_LSB = 24;
  localparam int ST_RX_CNT_LSB = 28;
  localparam int CNT_W         = 4;

  localparam int CTRL_FLUSH_BIT = 31;
  localparam logic [14:0] CTRL_RST_DEFAULT = 15'h1ED5;

  localparam int IRQ_TX_EMPTY = 0;
  localparam int IRQ_RX_NEMPTY = 1;
  localparam int IRQ_TX_OVR   = 2;
  localparam int IRQ_RX_UDR   = 3;
  localparam int IRQ_W        = 4;

endpackage

// File: rtl/i2s_hold_buf.sv
// Small holding FIFO with occupancy count; push and pop may coincide in one cycle.
module i2s_hold_buf
  import i2s_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty_o   = (cnt_q == 4'd0);
  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = {PW{1'b0}};
      rd_d  = {PW{1'b0}};
      cnt_d = 4'd0;
    end else begin
      if (do_push_s) wr_d = ptr_inc(wr_q);
      else           wr_d = wr_q;
      if (do_pop_s)  rd_d = ptr_inc(rd_q);
      else           rd_d = rd_q;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + 4'd1;
        2'b01:   cnt_d = cnt_q - 4'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= 4'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/i2s_apb_regbank.sv
// APB register bank bridging a CPU to an I2S core through TX/RX holding buffers.
// Interrupt support is compiled in only when I2S_REGBANK_IRQ_EN is defined.
module i2s_apb_regbank
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int HOLD_DEPTH = 4,
  parameter int CTRL_W     = 15,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEFAULT),
  parameter int FLAG_W     = 10,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [CTRL_W-1:0] controls,
  input  logic [FLAG_W-1:0] flags,
  output logic [DATA_W-1:0] tx_data,
  output logic [CH_W-1:0]   tx_ch,
  output logic              tx_wen,
  input  logic              tx_full,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ren,
  input  logic              rx_empty,
  output logic              irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              pend_q, pend_d;
  logic              tx_ovr_q, tx_ovr_d, rx_udr_q, rx_udr_d;

  logic              access_s, err_s, ctrl_wr_s, flush_s, tx_push_s, rx_pop_s, stat_rd_s;
  logic              ovr_evt_s, udr_evt_s, tx_wen_s, rx_ren_s;
  logic [31:0]       rdata_s, status_s;
  logic [DATA_W-1:0] txb_head_s, rxb_head_s;
  logic [CNT_W-1:0]  txb_cnt_s, rxb_cnt_s;
  logic              txb_full_s, txb_empty_s, rxb_full_s, rxb_empty_s;
  logic              unused_s;

`ifdef I2S_REGBANK_IRQ_EN
  logic [IRQ_W-1:0]  irq_en_q, irq_en_d, irq_stat_q, irq_stat_d, irq_evt_s;
  logic              irq_en_wr_s, irq_w1c_s, txb_empty_prev_q, rxb_ne_prev_q, irq_q;
`endif

  assign access_s = psel && penable;
  assign pready   = 1'b1;
  assign prdata   = rdata_s;
  assign pslverr  = err_s;
  assign controls = ctrl_q;
  assign tx_data  = txb_head_s;
  assign tx_ch    = ch_q;
  assign tx_wen   = tx_wen_s;
  assign rx_ren   = rx_ren_s;
  assign unused_s = ^{pwdata, rxb_full_s};

  // Only one RX read is ever outstanding, so the buffer count alone bounds issue.
  assign tx_wen_s = !preset && !txb_empty_s && !tx_full;
  assign rx_ren_s = !preset && !rx_empty && !pend_q && (rxb_cnt_s < CNT_W'(HOLD_DEPTH));

  always_comb begin
    status_s = 32'h0;
    status_s[FLAG_W-1:0] = flags;
    status_s[ST_TX_FULL]   = txb_full_s;
    status_s[ST_TX_EMPTY]  = txb_empty_s;
    status_s[ST_RX_NEMPTY] = !rxb_empty_s;
    status_s[ST_TX_OVR]    = tx_ovr_q;
    status_s[ST_RX_UDR]    = rx_udr_q;
    status_s[ST_TX_CNT_LSB +: CNT_W] = txb_cnt_s;
    status_s[ST_RX_CNT_LSB +: CNT_W] = rxb_cnt_s;
  end

  always_comb begin
    err_s     = 1'b0;
    rdata_s   = 32'h0;
    ctrl_wr_s = 1'b0;
    flush_s   = 1'b0;
    tx_push_s = 1'b0;
    rx_pop_s  = 1'b0;
    stat_rd_s = 1'b0;
    ovr_evt_s = 1'b0;
    udr_evt_s = 1'b0;
`ifdef I2S_REGBANK_IRQ_EN
    irq_en_wr_s = 1'b0;
    irq_w1c_s   = 1'b0;
`endif
    if (!access_s) begin
      err_s = 1'b0;
    end else if (paddr[1:0] != 2'b00) begin
      err_s = 1'b1;
    end else begin
      case (paddr)
        OFF_CTRL: begin
          if (pwrite) begin
            ctrl_wr_s = 1'b1;
            flush_s   = pwdata[CTRL_FLUSH_BIT];
          end else begin
            rdata_s = 32'(ctrl_q);
          end
        end
        OFF_TXDATA: begin
          if (!pwrite)         err_s = 1'b1;
          else if (txb_full_s) begin
            err_s     = 1'b1;
            ovr_evt_s = 1'b1;
          end else             tx_push_s = 1'b1;
        end
        OFF_RXDATA: begin
          if (pwrite)           err_s = 1'b1;
          else if (rxb_empty_s) begin
            err_s     = 1'b1;
            udr_evt_s = 1'b1;
          end else begin
            rdata_s  = 32'(rxb_head_s);
            rx_pop_s = 1'b1;
          end
        end
        OFF_STATUS: begin
          if (pwrite) err_s = 1'b1;
          else begin
            rdata_s   = status_s;
            stat_rd_s = 1'b1;
          end
        end
`ifdef I2S_REGBANK_IRQ_EN
        OFF_IRQ_EN: begin
          if (pwrite) irq_en_wr_s = 1'b1;
          else        rdata_s = 32'(irq_en_q);
        end
        OFF_IRQ_STAT: begin
          if (pwrite) irq_w1c_s = 1'b1;
          else        rdata_s = 32'(irq_stat_q);
        end
`endif
        default: err_s = 1'b1;
      endcase
    end
  end

  always_comb begin
    ctrl_d = ctrl_wr_s ? pwdata[CTRL_W-1:0] : ctrl_q;
    if (flush_s)       ch_d = {CH_W{1'b0}};
    else if (tx_wen_s) ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : ch_q + CH_W'(1);
    else               ch_d = ch_q;
    // A flush abandons the word the core is about to return.
    pend_d = rx_ren_s && !flush_s;
    if (ovr_evt_s)                   tx_ovr_d = 1'b1;
    else if (stat_rd_s || flush_s)   tx_ovr_d = 1'b0;
    else                             tx_ovr_d = tx_ovr_q;
    if (udr_evt_s)                   rx_udr_d = 1'b1;
    else if (stat_rd_s || flush_s)   rx_udr_d = 1'b0;
    else                             rx_udr_d = rx_udr_q;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ctrl_q   <= CTRL_RST;
      ch_q     <= {CH_W{1'b0}};
      pend_q   <= 1'b0;
      tx_ovr_q <= 1'b0;
      rx_udr_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      ch_q     <= ch_d;
      pend_q   <= pend_d;
      tx_ovr_q <= tx_ovr_d;
      rx_udr_q <= rx_udr_d;
    end
  end

  i2s_hold_buf #(.DATA_W(DATA_W), .DEPTH(HOLD_DEPTH)) u_tx_buf (
    .clk_i(pclk), .rst_i(preset), .flush_i(flush_s),
    .push_i(tx_push_s), .push_data_i(pwdata[DATA_W-1:0]), .pop_i(tx_wen_s),
    .head_o(txb_head_s), .count_o(txb_cnt_s), .full_o(txb_full_s), .empty_o(txb_empty_s)
  );

  i2s_hold_buf #(.DATA_W(DATA_W), .DEPTH(HOLD_DEPTH)) u_rx_buf (
    .clk_i(pclk), .rst_i(preset), .flush_i(flush_s),
    .push_i(pend_q), .push_data_i(rx_data), .pop_i(rx_pop_s),
    .head_o(rxb_head_s), .count_o(rxb_cnt_s), .full_o(rxb_full_s), .empty_o(rxb_empty_s)
  );

`ifdef I2S_REGBANK_IRQ_EN
  always_comb begin
    irq_evt_s = {IRQ_W{1'b0}};
    irq_evt_s[IRQ_TX_EMPTY]  = txb_empty_s && !txb_empty_prev_q;
    irq_evt_s[IRQ_RX_NEMPTY] = !rxb_empty_s && !rxb_ne_prev_q;
    irq_evt_s[IRQ_TX_OVR]    = ovr_evt_s;
    irq_evt_s[IRQ_RX_UDR]    = udr_evt_s;
    irq_en_d   = irq_en_wr_s ? pwdata[IRQ_W-1:0] : irq_en_q;
    irq_stat_d = (irq_stat_q & ~(irq_w1c_s ? pwdata[IRQ_W-1:0] : {IRQ_W{1'b0}})) | irq_evt_s;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      irq_en_q         <= {IRQ_W{1'b0}};
      irq_stat_q       <= {IRQ_W{1'b0}};
      txb_empty_prev_q <= 1'b1;
      rxb_ne_prev_q    <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      irq_en_q         <= irq_en_d;
      irq_stat_q       <= irq_stat_d;
      txb_empty_prev_q <= txb_empty_s;
      rxb_ne_prev_q    <= !rxb_empty_s;
      irq_q            <= |(irq_stat_d & irq_en_d);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_apb_regbank.sv
// Directed self-checking bench for i2s_apb_regbank (default parameters).
module tb_i2s_apb_regbank;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [14:0] controls;
  logic [9:0]  flags;
  logic [31:0] tx_data, rx_data;
  logic [0:0]  tx_ch;
  logic        tx_wen, tx_full, rx_ren, rx_empty, irq;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  i2s_apb_regbank dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .controls(controls), .flags(flags), .tx_data(tx_data), .tx_ch(tx_ch), .tx_wen(tx_wen),
    .tx_full(tx_full), .rx_data(rx_data), .rx_ren(rx_ren), .rx_empty(rx_empty), .irq(irq)
  );

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output logic rdy);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    rd = prdata; er = pslverr; rdy = pready;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, rdy;
    preset = 1'b1; rx_empty = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000_0000;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    total++; if (controls !== 15'h1ED5) begin bad++; $display("FAIL rst_controls got=%h exp=%h", controls, 15'h1ED5); end
    total++; if (rx_ren !== 1'b0) begin bad++; $display("FAIL rst_rx_ren got=%b exp=0", rx_ren); end
    total++; if (tx_wen !== 1'b0) begin bad++; $display("FAIL rst_tx_wen got=%b exp=0", tx_wen); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; rx_empty = 1'b1;
    apb(1'b0, 8'h00, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0000_1ED5) begin bad++; $display("FAIL rst_ctrl_read got=%h exp=%h", rd, 32'h0000_1ED5); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rst_ctrl_err got=%b exp=0", er); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rst_pready got=%b exp=1", rdy); end
  endtask

  task automatic test_status_idle();
    logic [31:0] rd; logic er, rdy;
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0002_02A5) begin bad++; $display("FAIL status_idle got=%h exp=%h", rd, 32'h0002_02A5); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic er, rdy;
    apb(1'b1, 8'h00, 32'h0000_1234, rd, er, rdy);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL ctrl_write got=%h/%b exp=0/0", rd, er); end
    total++; if (controls !== 15'h1234) begin bad++; $display("FAIL ctrl_controls got=%h exp=%h", controls, 15'h1234); end
    apb(1'b0, 8'h00, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0000_1234) begin bad++; $display("FAIL ctrl_readback got=%h exp=%h", rd, 32'h0000_1234); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, rdy;
    apb(1'b1, 8'h01, 32'h0, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_misaligned got=%b exp=1", er); end
    total++; if (controls !== 15'h1234) begin bad++; $display("FAIL err_ctrl_kept got=%h exp=%h", controls, 15'h1234); end
    apb(1'b0, 8'h20, 32'h0, rd, er, rdy);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_unmapped got=%b/%h exp=1/0", er, rd); end
    apb(1'b1, 8'h0C, 32'hFFFF_FFFF, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_wr_status got=%b exp=1", er); end
    apb(1'b0, 8'h04, 32'h0, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_rd_txdata got=%b exp=1", er); end
    apb(1'b1, 8'h08, 32'h5, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_wr_rxdata got=%b exp=1", er); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd, exp_d; logic er, rdy, exp_e; int n;
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb(1'b1, 8'h04, 32'h1111_0000 + 32'(i), rd, er, rdy);
      exp_e = (i == 4);
      total++; if (er !== exp_e) begin bad++; $display("FAIL tx_push_err[%0d] got=%b exp=%b", i, er, exp_e); end
    end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0409_02A5) begin bad++; $display("FAIL tx_ovr_status got=%h exp=%h", rd, 32'h0409_02A5); end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0401_02A5) begin bad++; $display("FAIL tx_ovr_cleared got=%h exp=%h", rd, 32'h0401_02A5); end
    tx_full = 1'b0; n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      if (tx_wen) begin
        exp_d = 32'h1111_0000 + 32'(n);
        total++; if (tx_data !== exp_d || tx_ch !== 1'(n % 2)) begin
          bad++; $display("FAIL tx_drain[%0d] got=%h/%0d exp=%h/%0d", n, tx_data, tx_ch, exp_d, n % 2);
        end
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL tx_drain_count got=%0d exp=4", n); end
  endtask

  task automatic test_rx_underflow();
    logic [31:0] rd; logic er, rdy;
    apb(1'b0, 8'h08, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL rx_udr_read got=%h/%b exp=0/1", rd, er); end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0012_02A5) begin bad++; $display("FAIL rx_udr_status got=%h exp=%h", rd, 32'h0012_02A5); end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0002_02A5) begin bad++; $display("FAIL rx_udr_cleared got=%h exp=%h", rd, 32'h0002_02A5); end
  endtask

  task automatic test_rx_fill();
    logic [31:0] rd, exp_d; logic er, rdy, got; int k;
    k = 0; rx_empty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk); got = rx_ren;
      @(posedge pclk); #1;
      if (got) begin rx_data = 32'hC000_0000 + 32'(k); k++; end
    end
    total++; if (k != 4) begin bad++; $display("FAIL rx_fill_pulses got=%0d exp=4", k); end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h4006_02A5) begin bad++; $display("FAIL rx_fill_status got=%h exp=%h", rd, 32'h4006_02A5); end
    apb(1'b0, 8'h08, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'hC000_0000 || er !== 1'b0) begin bad++; $display("FAIL rx_first_word got=%h/%b exp=%h/0", rd, er, 32'hC000_0000); end
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk); got = rx_ren;
      @(posedge pclk); #1;
      if (got) begin rx_data = 32'hC000_0000 + 32'(k); k++; end
    end
    total++; if (k != 5) begin bad++; $display("FAIL rx_refill_pulses got=%0d exp=5", k); end
    rx_empty = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      apb(1'b0, 8'h08, 32'h0, rd, er, rdy);
      exp_d = 32'hC000_0000 + 32'(i);
      total++; if (rd !== exp_d) begin bad++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, rd, exp_d); end
    end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0002_02A5) begin bad++; $display("FAIL rx_drained_status got=%h exp=%h", rd, 32'h0002_02A5); end
  endtask

  task automatic test_flush();
    logic [31:0] rd; logic er, rdy; int n;
    apb(1'b1, 8'h04, 32'hAAAA_0001, rd, er, rdy);
    repeat (3) @(posedge pclk);
    #1 tx_full = 1'b1;
    for (int i = 0; i < 3; i++) apb(1'b1, 8'h04, 32'hAAAA_0010 + 32'(i), rd, er, rdy);
    @(posedge pclk); #1;
    rx_empty = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h8000_1ED5;
    @(negedge pclk);
    total++; if (rx_ren !== 1'b1) begin bad++; $display("FAIL flush_rx_ren_setup got=%b exp=1", rx_ren); end
    @(posedge pclk); #1;
    rx_empty = 1'b1; rx_data = 32'hDEAD_BEEF; penable = 1'b1;
    @(negedge pclk);
    total++; if (pslverr !== 1'b0) begin bad++; $display("FAIL flush_err got=%b exp=0", pslverr); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; tx_full = 1'b0; n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      if (tx_wen) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL flush_tx_wen got=%0d exp=0", n); end
    apb(1'b0, 8'h0C, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0002_02A5) begin bad++; $display("FAIL flush_status got=%h exp=%h", rd, 32'h0002_02A5); end
    apb(1'b0, 8'h00, 32'h0, rd, er, rdy);
    total++; if (rd !== 32'h0000_1ED5) begin bad++; $display("FAIL flush_ctrl_read got=%h exp=%h", rd, 32'h0000_1ED5); end
    apb(1'b1, 8'h04, 32'hBBBB_0001, rd, er, rdy);
    @(negedge pclk);
    total++; if (tx_wen !== 1'b1 || tx_ch !== 1'b0 || tx_data !== 32'hBBBB_0001) begin
      bad++; $display("FAIL flush_ch_reset got=%b/%0d/%h exp=1/0/%h", tx_wen, tx_ch, tx_data, 32'hBBBB_0001);
    end
    repeat (2) @(posedge pclk);
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic er, rdy;
`ifdef I2S_REGBANK_IRQ_EN
    apb(1'b1, 8'h10, 32'h2, rd, er, rdy);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
    rx_empty = 1'b0;
    repeat (4) @(posedge pclk);
    #1 rx_empty = 1'b1;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx_fill got=%b exp=1", irq); end
    apb(1'b1, 8'h14, 32'h2, rd, er, rdy);
    @(negedge pclk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
`else
    apb(1'b0, 8'h10, 32'h0, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL irq_en_unmapped got=%b exp=1", er); end
    apb(1'b1, 8'h14, 32'hF, rd, er, rdy);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL irq_stat_unmapped got=%b exp=1", er); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied got=%b exp=0", irq); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 32'h0;
    flags = 10'h2A5; tx_full = 1'b0; rx_data = 32'h0; rx_empty = 1'b1; preset = 1'b1;
    test_reset();
    test_status_idle();
    test_ctrl();
    test_errors();
    test_tx_overflow();
    test_rx_underflow();
    test_rx_fill();
    test_flush();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_apb_regbank.md
I2S_APB_REGBANK -- requirements
Module: i2s_apb_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, audio word width (8..32).
REQ-002 SHALL have parameter NUM_CH, default 2, channels interleaved per frame (1..8).
REQ-003 SHALL have parameter HOLD_DEPTH, default 4, entries per direction holding buffer (2..8).
REQ-004 SHALL have parameter CTRL_W, default 15, control field width; CTRL_RST, default 15'h1ED5, control reset value; FLAG_W, default 10, core flag width.
REQ-005 SHALL use one clock and a synchronous, active-high reset; ports: pclk in 1 clock; preset in 1 reset.
REQ-006 SHALL have APB ports: psel in 1; penable in 1; pwrite in 1; paddr in 8 byte address; pwdata in 32; prdata out 32; pready out 1; pslverr out 1.
REQ-007 SHALL have core ports: controls out CTRL_W; flags in FLAG_W; tx_data out DATA_W; tx_ch out clog2(NUM_CH) channel tag; tx_wen out 1; tx_full in 1; rx_data in DATA_W; rx_ren out 1; rx_empty in 1; irq out 1.

Function
REQ-008 SHALL decode, word aligned: 0x00 CTRL RW, 0x04 TXDATA WO, 0x08 RXDATA RO, 0x0C STATUS RO, 0x10 IRQ_EN RW, 0x14 IRQ_STAT W1C.
REQ-009 SHALL complete every transfer in the first access cycle (psel&penable): pready=1, write committed at that edge.
REQ-010 SHALL drive prdata combinationally during read access phase, 0 otherwise; pslverr valid only in access phase.
REQ-011 SHALL raise pslverr for: unmapped or misaligned paddr, write to RO, read of TXDATA; register state unchanged.
REQ-012 SHALL push pwdata[DATA_W-1:0] into TX buffer on TXDATA write; if buffer full: pslverr=1, data dropped, sticky TX_OVR set.
REQ-013 SHALL pop RX buffer head on RXDATA read (zero-extended); if empty: prdata=0, pslverr=1, sticky RX_UDR set.
REQ-014 SHALL drain TX: when buffer non-empty and !tx_full, assert tx_wen one cycle with tx_data=head, tx_ch=current TX channel; pop at same edge.
REQ-015 SHALL fill RX: when rx_empty=0, no read outstanding and (count+outstanding)<HOLD_DEPTH, assert rx_ren one cycle; capture rx_data on the following edge.
REQ-016 SHALL allow simultaneous push and pop on either buffer in one cycle; count unchanged, order preserved.
REQ-017 SHALL advance TX channel counter per tx_wen, wrapping NUM_CH-1 -> 0.
REQ-018 SHALL map STATUS: [FLAG_W-1:0] flags, [16] TX full, [17] TX empty, [18] RX non-empty, [19] TX_OVR, [20] RX_UDR, [27:24] TX count, [31:28] RX count.
REQ-019 SHALL treat CTRL bit 31 as self-clearing FLUSH: empties both buffers, zeroes channel counter and sticky bits next edge; reads as 0; an in-flight rx_ren capture is discarded.
REQ-020 SHALL clear sticky TX_OVR/RX_UDR on STATUS read.

Reset
REQ-021 SHALL, while preset=1 at pclk edge: controls=CTRL_RST, buffers empty, counters 0, sticky and IRQ bits 0, tx_wen=0, rx_ren=0, irq=0, outstanding read dropped.
REQ-022 SHALL hold reset behaviour mid-transfer; an APB access coincident with preset has no effect.

Configuration
REQ-023 SHALL compile interrupts only with I2S_REGBANK_IRQ_EN defined: IRQ_STAT bits [0] TX buffer became empty, [1] RX became non-empty, [2] TX_OVR event, [3] RX_UDR event; irq registered = |(IRQ_STAT & IRQ_EN).
REQ-024 SHALL, without I2S_REGBANK_IRQ_EN: irq tied 0, 0x10/0x14 unmapped (pslverr).

Structure
REQ-025 SHALL place register offsets, STATUS bit positions, CTRL_RST default and IRQ bit indices in shared package i2s_pkg.
REQ-026 SHALL instantiate sub-module i2s_hold_buf (parametrised DATA_W/HOLD_DEPTH FIFO with count) twice, TX and RX.

Verification
REQ-027 SHALL cover: reset, read 0x00 -> prdata=0x00001ED5, pslverr=0.
REQ-028 SHALL cover: tx_full=1, 5 TXDATA writes (depth 4) -> 5th pslverr=1, STATUS[19]=1, [27:24]=4; release tx_full -> 4 tx_wen, tx_ch 0,1,0,1.
REQ-029 SHALL cover: RXDATA read with RX empty -> prdata=0, pslverr=1, STATUS[20]=1, cleared after STATUS read.
REQ-030 SHALL cover: rx_empty=0 continuously -> rx_ren pulses stop at RX count 4; one RXDATA read -> exactly one further rx_ren.
REQ-031 SHALL cover: FLUSH with 3 TX words queued and rx_ren in flight -> next cycle counts 0, no tx_wen, captured RX word discarded.
REQ-032 SHALL cover (IRQ_EN build): IRQ_EN=0x2, RX fills -> irq=1; write 0x2 to IRQ_STAT -> irq=0 next cycle.
